// File: rtl/fwd_track_if.sv
// Bundle of fwd_track producer insertion, fill, lookup and writeback signals.
// Latency: n/a (wires only); lookup outputs are combinational in the slave.
// Backpressure: none; upstream stalls itself using the hazard vector.
interface fwd_track_if #(
   parameter int XLEN  = 32,
   parameter int AW    = 5,
   parameter int DEPTH = 3,
   parameter int NSRC  = 2,
   parameter int LW    = $clog2(DEPTH)
);
   logic                        advance;
   logic                        flush;
   logic                        in_valid;
   logic [AW-1:0]               in_addr;
   logic [LW-1:0]               in_lat;
   logic [XLEN-1:0]             in_data;
   logic [(DEPTH-1)*XLEN-1:0]   fill_data;
   logic [NSRC*AW-1:0]          src_addr;
   logic [NSRC*XLEN-1:0]        rf_data;
   logic [NSRC*XLEN-1:0]        fwd_data;
   logic [NSRC-1:0]             hazard;
   logic                        wb_valid;
   logic [AW-1:0]               wb_addr;
   logic [XLEN-1:0]             wb_data;
   logic [15:0]                 hazard_cnt;

   // Upstream pipeline / register file side.
   modport master (
      output advance, flush, in_valid, in_addr, in_lat, in_data,
             fill_data, src_addr, rf_data,
      input  fwd_data, hazard, wb_valid, wb_addr, wb_data, hazard_cnt
   );

   // Tracking unit side.
   modport slave (
      input  advance, flush, in_valid, in_addr, in_lat, in_data,
             fill_data, src_addr, rf_data,
      output fwd_data, hazard, wb_valid, wb_addr, wb_data, hazard_cnt
   );
endinterface

// File: rtl/fwd_track.sv
// Shadow pipeline of in-flight register writes; forwards youngest ready result.
// Latency: insertion visible next cycle; lookup combinational; writeback after DEPTH-1 advances.
// Backpressure: none internal; hazard tells upstream to hold and insert bubbles.
module fwd_track #(
   parameter int XLEN  = 32,
   parameter int AW    = 5,
   parameter int DEPTH = 3,
   parameter int NSRC  = 2,
   parameter int LW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   fwd_track_if.slave  bus
);
   localparam int LAST = DEPTH - 1;

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DEPTH-1:0]  rdy_q,   rdy_d;
   logic [AW-1:0]     addr_q [DEPTH];
   logic [AW-1:0]     addr_d [DEPTH];
   logic [LW-1:0]     lat_q  [DEPTH];
   logic [LW-1:0]     lat_d  [DEPTH];
   logic [XLEN-1:0]   data_q [DEPTH];
   logic [XLEN-1:0]   data_d [DEPTH];
   logic [15:0]       cnt_q,   cnt_d;

   logic [NSRC-1:0]   hit;
   logic [NSRC-1:0]   hit_rdy;
   logic [XLEN-1:0]   hit_data [NSRC];

   // Next state: insert at stage 0 and shift on advance, capturing fill results in flight.
   always_comb begin
      valid_d = valid_q;
      rdy_d   = rdy_q;
      addr_d  = addr_q;
      lat_d   = lat_q;
      data_d  = data_q;
      if (bus.advance) begin
         // Address 0 is the zero register, so it never becomes a tracked write.
         valid_d[0] = bus.in_valid & ~bus.flush & (bus.in_addr != '0);
         addr_d[0]  = bus.in_addr;
         lat_d[0]   = (bus.in_lat > LW'(LAST)) ? LW'(LAST) : bus.in_lat;
         rdy_d[0]   = (bus.in_lat == '0);
         data_d[0]  = (bus.in_lat == '0) ? bus.in_data : '0;
         for (int k = 0; k < LAST; k++) begin
            valid_d[k+1] = valid_q[k];
            rdy_d[k+1]   = rdy_q[k];
            addr_d[k+1]  = addr_q[k];
            lat_d[k+1]   = lat_q[k];
            data_d[k+1]  = data_q[k];
            // The unit in stage k produces this entry's result as it moves on.
            if (valid_q[k] && !rdy_q[k] && (lat_q[k] == LW'(k + 1))) begin
               rdy_d[k+1]  = 1'b1;
               data_d[k+1] = bus.fill_data[k*XLEN +: XLEN];
            end
         end
      end
   end

   // Hazard-cycle counter, saturating, runs regardless of advance.
   always_comb begin
      cnt_d = cnt_q;
      if ((|bus.hazard) && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // State registers; reset drops every in-flight write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         rdy_q   <= '0;
         cnt_q   <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            addr_q[k] <= '0;
            lat_q[k]  <= '0;
            data_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         rdy_q   <= rdy_d;
         cnt_q   <= cnt_d;
         for (int k = 0; k < DEPTH; k++) begin
            addr_q[k] <= addr_d[k];
            lat_q[k]  <= lat_d[k];
            data_q[k] <= data_d[k];
         end
      end
   end

   // Per-port lookup: scan oldest to youngest so the youngest match overrides.
   // An unready youngest match hides any older ready one.
   always_comb begin
      hit          = '0;
      hit_rdy      = '0;
      bus.fwd_data = bus.rf_data;
      bus.hazard   = '0;
      for (int i = 0; i < NSRC; i++) begin
         hit_data[i] = '0;
         for (int k = LAST; k >= 0; k--) begin
            if (valid_q[k] && (addr_q[k] == bus.src_addr[i*AW +: AW]) &&
                (bus.src_addr[i*AW +: AW] != '0)) begin
               hit[i]      = 1'b1;
               hit_rdy[i]  = rdy_q[k];
               hit_data[i] = data_q[k];
            end
         end
         if (hit[i] && hit_rdy[i]) begin
            bus.fwd_data[i*XLEN +: XLEN] = hit_data[i];
         end
         bus.hazard[i] = hit[i] & ~hit_rdy[i];
      end
   end

   // The oldest stage is the register-file write port.
   assign bus.wb_valid   = valid_q[LAST];
   assign bus.wb_addr    = addr_q[LAST];
   assign bus.wb_data    = data_q[LAST];
   assign bus.hazard_cnt = cnt_q;
endmodule

// File: tb/tb_fwd_track.sv
// Directed bench for fwd_track with DEPTH=3.
// Inputs change 2 time units after a rising edge; outputs are checked before the next edge.
// Each scenario task carries its own hand-computed expectations.
module tb_fwd_track;
   localparam int XLEN  = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 3;
   localparam int NSRC  = 2;
   localparam int LW    = 2;

   localparam logic [31:0] RF0 = 32'h0000_1111;
   localparam logic [31:0] RF1 = 32'h0000_2222;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   fwd_track_if #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .NSRC(NSRC), .LW(LW)) bus ();

   fwd_track #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .NSRC(NSRC), .LW(LW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      bus.advance   = 1'b0;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_addr   = '0;
      bus.in_lat    = '0;
      bus.in_data   = '0;
      bus.fill_data = '0;
      bus.src_addr  = '0;
      bus.rf_data   = {RF1, RF0};
   endtask

   task automatic insert(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [XLEN-1:0] d);
      bus.advance  = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_addr  = a;
      bus.in_lat   = l;
      bus.in_data  = d;
      tick();
      bus.advance  = 1'b0;
      bus.in_valid = 1'b0;
   endtask

   task automatic adv(input logic [2*XLEN-1:0] fill);
      bus.fill_data = fill;
      bus.advance   = 1'b1;
      tick();
      bus.advance   = 1'b0;
      bus.fill_data = '0;
   endtask

   task automatic set_src(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      bus.src_addr = {a1, a0};
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      idle();
      bus.advance  = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_addr  = 5'd7;
      bus.src_addr = {5'd7, 5'd7};
      bus.rf_data  = {32'h55AA, 32'h55AA};
      #1 rst_n = 1'b0;
      tick(); tick(); tick();
      n_tests++; if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b want 0", bus.wb_valid); end
      n_tests++; if (bus.hazard !== 2'b00) begin n_fail++; $display("FAIL reset_hazard: got %b want 00", bus.hazard); end
      n_tests++; if (bus.hazard_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", bus.hazard_cnt); end
      n_tests++; if (bus.fwd_data !== {32'h55AA, 32'h55AA}) begin n_fail++; $display("FAIL reset_fwd: got %h want %h", bus.fwd_data, {32'h55AA, 32'h55AA}); end
      idle();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_alu_path();
      do_reset();
      insert(5'd8, 2'd1, 32'h999);
      set_src(5'd8, 5'd0);
      n_tests++; if (bus.hazard !== 2'b01) begin n_fail++; $display("FAIL alu_hazard: got %b want 01", bus.hazard); end
      n_tests++; if (bus.fwd_data[31:0] !== RF0) begin n_fail++; $display("FAIL alu_fwd_rf: got %h want %h", bus.fwd_data[31:0], RF0); end
      adv({32'h0, 32'h1234});
      n_tests++; if (bus.fwd_data[31:0] !== 32'h1234) begin n_fail++; $display("FAIL alu_fwd_fill: got %h want 1234", bus.fwd_data[31:0]); end
      n_tests++; if (bus.hazard !== 2'b00) begin n_fail++; $display("FAIL alu_hazard_clr: got %b want 00", bus.hazard); end
      n_tests++; if (bus.hazard_cnt !== 16'd1) begin n_fail++; $display("FAIL alu_cnt: got %0d want 1", bus.hazard_cnt); end
      n_tests++; if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_wb_early: got %b want 0", bus.wb_valid); end
      adv('0);
      n_tests++; if ({bus.wb_valid, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd8, 32'h1234}) begin n_fail++; $display("FAIL alu_wb: got %b/%0d/%h want 1/8/1234", bus.wb_valid, bus.wb_addr, bus.wb_data); end
      n_tests++; if (bus.fwd_data[31:0] !== 32'h1234) begin n_fail++; $display("FAIL alu_fwd_wb_stage: got %h want 1234", bus.fwd_data[31:0]); end
   endtask

   task automatic test_youngest();
      do_reset();
      insert(5'd5, 2'd0, 32'hA);
      insert(5'd5, 2'd0, 32'hB);
      set_src(5'd5, 5'd5);
      n_tests++; if (bus.fwd_data !== {32'hB, 32'hB}) begin n_fail++; $display("FAIL young_fwd: got %h want %h", bus.fwd_data, {32'hB, 32'hB}); end
      n_tests++; if (bus.hazard !== 2'b00) begin n_fail++; $display("FAIL young_hazard: got %b want 00", bus.hazard); end
      set_src(5'd0, 5'd0);
      insert(5'd5, 2'd2, 32'hC);
      set_src(5'd5, 5'd5);
      n_tests++; if (bus.hazard !== 2'b11) begin n_fail++; $display("FAIL young_unready_hazard: got %b want 11", bus.hazard); end
      n_tests++; if (bus.fwd_data !== {RF1, RF0}) begin n_fail++; $display("FAIL young_unready_fwd: got %h want %h", bus.fwd_data, {RF1, RF0}); end
   endtask

   task automatic test_load_use();
      do_reset();
      insert(5'd3, 2'd2, 32'h0);
      adv('0);
      set_src(5'd3, 5'd0);
      n_tests++; if (bus.hazard !== 2'b01) begin n_fail++; $display("FAIL lu_hazard_start: got %b want 01", bus.hazard); end
      for (int c = 0; c < 3; c++) begin
         bus.fill_data = {32'hBAD0, 32'hBAD1};
         tick();
         n_tests++; if (bus.hazard !== 2'b01) begin n_fail++; $display("FAIL lu_hazard_hold%0d: got %b want 01", c, bus.hazard); end
      end
      n_tests++; if (bus.hazard_cnt !== 16'd3) begin n_fail++; $display("FAIL lu_cnt: got %0d want 3", bus.hazard_cnt); end
      adv({32'hDEAD, 32'h0});
      n_tests++; if (bus.fwd_data[31:0] !== 32'hDEAD) begin n_fail++; $display("FAIL lu_fwd: got %h want dead", bus.fwd_data[31:0]); end
      n_tests++; if (bus.hazard !== 2'b00) begin n_fail++; $display("FAIL lu_hazard_clr: got %b want 00", bus.hazard); end
      n_tests++; if ({bus.wb_valid, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd3, 32'hDEAD}) begin n_fail++; $display("FAIL lu_wb: got %b/%0d/%h want 1/3/dead", bus.wb_valid, bus.wb_addr, bus.wb_data); end
      n_tests++; if (bus.hazard_cnt !== 16'd4) begin n_fail++; $display("FAIL lu_cnt_final: got %0d want 4", bus.hazard_cnt); end
   endtask

   task automatic test_lat_clamp();
      do_reset();
      insert(5'd10, 2'd3, 32'h0);
      adv({32'h0, 32'h1});
      set_src(5'd10, 5'd0);
      n_tests++; if (bus.hazard !== 2'b01) begin n_fail++; $display("FAIL clamp_hazard: got %b want 01", bus.hazard); end
      adv({32'h2, 32'h0});
      n_tests++; if (bus.fwd_data[31:0] !== 32'h2) begin n_fail++; $display("FAIL clamp_fwd: got %h want 2", bus.fwd_data[31:0]); end
      n_tests++; if ({bus.wb_valid, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd10, 32'h2}) begin n_fail++; $display("FAIL clamp_wb: got %b/%0d/%h want 1/10/2", bus.wb_valid, bus.wb_addr, bus.wb_data); end
   endtask

   task automatic test_bubbles();
      do_reset();
      insert(5'd0, 2'd0, 32'h77);
      bus.flush = 1'b1;
      insert(5'd9, 2'd0, 32'h99);
      bus.flush = 1'b0;
      set_src(5'd0, 5'd9);
      n_tests++; if (bus.fwd_data !== {RF1, RF0}) begin n_fail++; $display("FAIL bub_fwd: got %h want %h", bus.fwd_data, {RF1, RF0}); end
      n_tests++; if (bus.hazard !== 2'b00) begin n_fail++; $display("FAIL bub_hazard: got %b want 00", bus.hazard); end
      for (int c = 0; c < 3; c++) begin
         adv('0);
         n_tests++; if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL bub_wb%0d: got %b want 0", c, bus.wb_valid); end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      insert(5'd4, 2'd0, 32'h44);
      insert(5'd6, 2'd2, 32'h0);
      set_src(5'd6, 5'd4);
      n_tests++; if (bus.hazard !== 2'b01) begin n_fail++; $display("FAIL ar_hazard: got %b want 01", bus.hazard); end
      n_tests++; if (bus.fwd_data[63:32] !== 32'h44) begin n_fail++; $display("FAIL ar_fwd1: got %h want 44", bus.fwd_data[63:32]); end
      adv('0);
      n_tests++; if ({bus.wb_valid, bus.hazard} !== 3'b101) begin n_fail++; $display("FAIL ar_pre: got wb=%b hz=%b want wb=1 hz=01", bus.wb_valid, bus.hazard); end
      rst_n = 1'b0;
      #1;
      n_tests++; if ({bus.wb_valid, bus.hazard} !== 3'b000) begin n_fail++; $display("FAIL ar_drop: got wb=%b hz=%b want 0/00", bus.wb_valid, bus.hazard); end
      n_tests++; if (bus.fwd_data !== {RF1, RF0}) begin n_fail++; $display("FAIL ar_fwd_rf: got %h want %h", bus.fwd_data, {RF1, RF0}); end
      n_tests++; if (bus.hazard_cnt !== 16'd0) begin n_fail++; $display("FAIL ar_cnt: got %0d want 0", bus.hazard_cnt); end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         adv('0);
         n_tests++; if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL ar_wb%0d: got %b want 0", c, bus.wb_valid); end
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_alu_path();
      test_youngest();
      test_load_use();
      test_lat_clamp();
      test_bubbles();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fwd_track.md
# fwd_track

Parametrised result-tracking bypass unit. It replaces fixed per-operand forwarding muxes with a single pipelined scoreboard. The block owns a DEPTH-stage shadow pipeline of in-flight register writes `{valid, addr, lat, rdy, data}`. It forwards the youngest matching ready result to NSRC read ports and raises a per-port hazard when the youngest producer has not yet produced its data. The last stage drives the register-file write port. A saturating counter records hazard cycles.

## Interface
- `XLEN`, 32, datapath width
- `AW`, 5, register address width; register 0 is hard-wired zero
- `DEPTH`, 3, tracked stages, ≥2; stage DEPTH-1 is writeback
- `NSRC`, 2, number of read ports
- `LW`, $clog2(DEPTH), width of `in_lat`
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `advance`  in  1  pipeline shift enable
- `flush`  in  1  insert bubble instead of incoming producer
- `in_valid`  in  1  producer present at insertion
- `in_addr`  in  AW  producer destination
- `in_lat`  in  LW  advances until data ready; 0 means `in_data` valid now
- `in_data`  in  XLEN  immediate result, e.g. PC+8
- `fill_data`  in  (DEPTH-1)*XLEN  slice k is the result computed in stage k (ALU, DM, ...)
- `src_addr`  in  NSRC*AW  read addresses
- `rf_data`  in  NSRC*XLEN  register-file read values
- `fwd_data`  out  NSRC*XLEN  forwarded operands, combinational
- `hazard`  out  NSRC  youngest producer not ready, combinational
- `wb_valid`  out  1  stage DEPTH-1 holds a write
- `wb_addr`  out  AW  write address
- `wb_data`  out  XLEN  write data
- `hazard_cnt`  out  16  saturating count of cycles with any hazard

## Operation
- Insertion, on a clock edge with advance=1:
  - stage0.valid <= in_valid & ~flush & (in_addr≠0).
  - addr <= in_addr.
  - lat <= min(in_lat, DEPTH-1).
  - rdy <= (in_lat==0).
  - data <= in_lat==0 ? in_data : 0.
- Shift, on a clock edge with advance=1, for k = 0..DEPTH-2: stage k+1 <= stage k. If stage k is valid, not rdy, and lat==k+1, the moving entry captures `fill_data[k]` and sets rdy=1. The stage DEPTH-1 entry retires.
- advance=0: all stages hold. No fill capture. `in_*` and `flush` are ignored.
- Entries with addr 0 are never valid.
- Lookup, per port i, combinational:
  - Candidates are valid stages with addr==src_addr[i]; src_addr 0 never matches. The lowest stage index (youngest) wins.
  - No match: fwd_data = rf_data[i], hazard = 0.
  - Match with rdy=1: fwd_data = entry data, hazard = 0.
  - Match with rdy=0: fwd_data = rf_data[i] (not to be consumed), hazard = 1. An older ready match must NOT be forwarded in this case.
- Writeback: wb_valid / wb_addr / wb_data = stage DEPTH-1 valid / addr / data. An entry reaching DEPTH-1 is always rdy, because lat ≤ DEPTH-1.
- Because stage DEPTH-1 is included in lookup, the register file needs no internal write-through.
- hazard_cnt: on a clock edge where |hazard, increments and saturates at 0xFFFF. Independent of advance.
- Stalling is the upstream's job: on hazard it holds its own stages and presents in_valid=0 (or flush) while advance stays 1.

## Timing
- rst_n low, asynchronously:
  - All valid, rdy, data, addr, lat and hazard_cnt clear to 0.
  - wb_valid=0, wb_addr=0, wb_data=0.
  - hazard=0; fwd_data=rf_data.
- Release is synchronous to the next clk edge.
- An insertion is visible to lookup in the cycle after its edge.
- A lat=L producer forwards from the cycle after its L-th advance. It writes back in the cycle after its (DEPTH-1)-th advance after insertion.
- fill_data must be stable before the capturing edge. It is sampled only on edges with advance=1.
- Reset mid-operation drops all in-flight writes. No writeback occurs for them.

## Test plan
- Reset: rst_n=0 with arbitrary inputs -> wb_valid=0, hazard=0, hazard_cnt=0, fwd_data=rf_data=0x55AA.
- ALU path (DEPTH=3):
  - Insert addr 8, lat 1 -> next cycle src0=8 gives hazard[0]=1.
  - Then fill_data[0]=0x1234 with advance -> fwd_data[0]=0x1234, hazard 0.
  - One more advance -> wb_valid=1, wb_addr=8, wb_data=0x1234.
- Youngest wins: stage1 has addr 5 ready with 0xA; insert addr 5, lat 0, in_data 0xB -> fwd_data=0xB on both ports reading 5.
- Load-use:
  - Producer addr 3, lat 2 sitting in stage1, advance=0 for 3 cycles -> hazard=1 throughout, hazard_cnt=3.
  - Advance with fill_data[1]=0xDEAD -> fwd 0xDEAD, hazard 0.
- Bubbles: insert addr 0, then addr 9 with flush=1 -> no later wb_valid; src 0 and src 9 both forward rf_data.
- Async reset mid-flight: assert rst_n low between edges with 2 valid entries -> wb_valid and hazard drop immediately; after release, no writeback occurs.
